// File: rtl/wb_master_port.sv
// Wishbone classic single-transfer master: turns one CPU byte/word request into one
// bus cycle with lane steering, ack wait, aligned read return, misalign/timeout errors.
module wb_master_port #(
    parameter int ADDR    = 16,
    parameter int TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            req_we_i,
    input  logic            req_byte_i,
    input  logic [ADDR-1:0] req_adr_i,
    input  logic [15:0]     req_dat_i,
    output logic            req_rdy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [15:0]     rdat_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [1:0]      sel_o,
    output logic [ADDR-2:0] adr_o,
    output logic [15:0]     dat_o,
    input  logic            ack_i,
    input  logic [15:0]     dat_i,
    output logic [1:0]      state_o
);

    // Handshake: a request is taken on any rising edge where req_i=1 and req_rdy_o=1;
    // done_o/err_o are single-cycle pulses, never both high; ack_i counts only in BUS.

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          we_q;
    logic [CW-1:0] cnt;
    logic          misaligned;
    logic          start;
    logic          timeout_hit;
    logic          done_nxt;
    logic          err_nxt;
    logic          capture;

    assign misaligned  = !req_byte_i && req_adr_i[0];
    assign start       = (state == S_IDLE) && req_i && !misaligned;
    // The abort lands on the edge where the counter would reach TIMEOUT.
    assign timeout_hit = (TIMEOUT > 0) && (cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_i) begin
                    if (misaligned) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_GAP;
                    end else begin
                        state_nxt = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (ack_i) begin
                    done_nxt  = 1'b1;
                    capture   = !we_q;
                    state_nxt = S_GAP;
                end else if (timeout_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= S_IDLE;
            done_o <= 1'b0;
            err_o  <= 1'b0;
            we_q   <= 1'b0;
            adr_o  <= '0;
            sel_o  <= 2'b00;
            dat_o  <= 16'h0000;
            rdat_o <= 16'h0000;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            done_o <= done_nxt;
            err_o  <= err_nxt;
            if (start) begin
                we_q  <= req_we_i;
                adr_o <= req_adr_i[ADDR-1:1];
                cnt   <= '0;
                if (req_byte_i) begin
                    sel_o <= req_adr_i[0] ? 2'b10 : 2'b01;
                    dat_o <= {req_dat_i[7:0], req_dat_i[7:0]};
                end else begin
                    sel_o <= 2'b11;
                    dat_o <= req_dat_i;
                end
            end else if (state == S_BUS && !ack_i && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            // Only the selected lanes of dat_i are looked at; the others may be X.
            if (capture) begin
                if (sel_o == 2'b11)
                    rdat_o <= dat_i;
                else if (sel_o[1])
                    rdat_o <= {8'h00, dat_i[15:8]};
                else
                    rdat_o <= {8'h00, dat_i[7:0]};
            end
        end
    end

    assign cyc_o     = (state == S_BUS);
    assign stb_o     = (state == S_BUS);
    assign we_o      = we_q && (state == S_BUS);
    assign req_rdy_o = (state == S_IDLE);
    assign state_o   = state;

endmodule

// File: tb/tb_wb_master_port.sv
// Bench for wb_master_port: byte-memory slave with selectable ack behaviour,
// vector table from the test plan, corner sequences and a random pass vs a byte-array model.
module tb_wb_master_port;

  localparam int ADDR    = 16;
  localparam int TIMEOUT = 15;

  localparam int M_NEG  = 0;
  localparam int M_NONE = 1;
  localparam int M_HOLD = 2;
  localparam int M_REG  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic        req_byte_i = 1'b0;
  logic [15:0] req_adr_i = 16'h0;
  logic [15:0] req_dat_i = 16'h0;
  logic        req_rdy_o, done_o, err_o, cyc_o, stb_o, we_o;
  logic [15:0] rdat_o, dat_o, dat_i;
  logic [1:0]  sel_o, state_o;
  logic [14:0] adr_o;
  logic        ack_i;

  int checks = 0;
  int errors = 0;
  int mode = M_NEG;
  logic [15:0] exp_rdat = 16'h0;

  always #5 clk = ~clk;

  wb_master_port #(.ADDR(ADDR), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_i(req_i), .req_we_i(req_we_i), .req_byte_i(req_byte_i),
    .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .req_rdy_o(req_rdy_o), .done_o(done_o), .err_o(err_o), .rdat_o(rdat_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
    .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i), .state_o(state_o)
  );

  // ---------------- slave memory ----------------
  logic [7:0]  smem [0:65535];
  logic        ack_neg = 1'b0;
  logic        ack_reg = 1'b0;
  logic        stb_prev = 1'b0;
  logic [15:0] garb = 16'h0;

  always @(negedge clk) begin
    garb     <= 16'($urandom);
    ack_neg  <= (mode == M_HOLD) ? (stb_o | stb_prev) : stb_o;
    stb_prev <= stb_o;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_reg <= 1'b0;
    else        ack_reg <= stb_o & ~ack_reg;
  end

  assign ack_i = (mode == M_NEG || mode == M_HOLD) ? ack_neg :
                 (mode == M_REG) ? ack_reg : 1'b0;

  always_comb begin
    dat_i = garb;
    if (sel_o[0]) dat_i[7:0]  = smem[{adr_o, 1'b0}];
    if (sel_o[1]) dat_i[15:8] = smem[{adr_o, 1'b1}];
  end

  always @(posedge clk) begin
    if (ack_i && stb_o && we_o) begin
      if (sel_o[0]) smem[{adr_o, 1'b0}] <= dat_o[7:0];
      if (sel_o[1]) smem[{adr_o, 1'b1}] <= dat_o[15:8];
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_req(input logic we, input logic bt, input logic [15:0] adr,
                        input logic [15:0] dat, output logic got_done,
                        output logic got_err, output int lat, output int stb_cycles,
                        output logic [1:0] s_sel, output logic [14:0] s_adr,
                        output logic [15:0] s_dat, output logic s_we);
    int guard;
    guard = 0;
    got_done = 1'b0; got_err = 1'b0; lat = 0; stb_cycles = 0;
    s_sel = 2'b00; s_adr = 15'h0; s_dat = 16'h0; s_we = 1'b0;
    while (!req_rdy_o && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!req_rdy_o) begin
      chk("rdy_wait", 32'(req_rdy_o), 32'd1);
      return;
    end
    req_i = 1'b1; req_we_i = we; req_byte_i = bt; req_adr_i = adr; req_dat_i = dat;
    @(posedge clk); #1;
    req_i = 1'b0;
    s_sel = sel_o; s_adr = adr_o; s_dat = dat_o; s_we = we_o;
    while (lat <= 40) begin
      if (stb_o) stb_cycles++;
      if (done_o || err_o) break;
      @(posedge clk); #1;
      lat++;
    end
    got_done = done_o;
    got_err  = err_o;
    if (!(got_done || got_err)) begin
      chk("completion_bound", 32'd0, 32'd1);
      return;
    end
    chk("pulse_exclusive", 32'(got_done & got_err), 32'd0);
    @(posedge clk); #1;
    chk("post_quiet", {30'd0, done_o, err_o}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic        bt;
    logic [15:0] adr;
    logic [15:0] dat;
    logic        exp_err;
    logic [1:0]  exp_sel;
    logic [14:0] exp_adr;
    logic [15:0] exp_dat;
    logic [15:0] exp_rdat;
  } vec_t;

  vec_t vt [8];

  logic [7:0] ref_mem [0:63];

  task automatic rand_op(input logic we, input logic bt, input logic [5:0] off,
                         input logic [15:0] dat);
    logic d, e, ssw;
    int lat, sc, exp_lat;
    logic [1:0] ss;
    logic [14:0] sa;
    logic [15:0] sd;
    logic misal;
    misal   = !bt && off[0];
    exp_lat = (mode == M_REG) ? 2 : 1;
    do_req(we, bt, 16'h0100 + 16'(off), dat, d, e, lat, sc, ss, sa, sd, ssw);
    if (misal) begin
      chk("rnd_misal_err", 32'(e), 32'd1);
      chk("rnd_misal_stb", 32'(sc), 32'd0);
    end else begin
      chk("rnd_done", 32'(d), 32'd1);
      chk("rnd_lat", 32'(lat), 32'(exp_lat));
      if (we) begin
        ref_mem[off] = dat[7:0];
        if (!bt) ref_mem[off + 6'd1] = dat[15:8];
      end else if (bt) begin
        exp_rdat = {8'h00, ref_mem[off]};
      end else begin
        exp_rdat = {ref_mem[off + 6'd1], ref_mem[off]};
      end
    end
    chk("rnd_rdat", 32'(rdat_o), 32'(exp_rdat));
  endtask

  initial begin
    logic d, e, ssw;
    int lat, sc;
    logic [1:0] ss;
    logic [14:0] sa;
    logic [15:0] sd;

    vt[0] = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, 2'b11, 15'h0008, 16'hBEEF, 16'h0000};
    vt[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 2'b11, 15'h0008, 16'h0000, 16'hBEEF};
    vt[2] = '{1'b1, 1'b1, 16'h0021, 16'hAB12, 1'b0, 2'b10, 15'h0010, 16'h1212, 16'hBEEF};
    vt[3] = '{1'b1, 1'b1, 16'h0020, 16'h5634, 1'b0, 2'b01, 15'h0010, 16'h3434, 16'hBEEF};
    vt[4] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 2'b11, 15'h0010, 16'h0000, 16'h1234};
    vt[5] = '{1'b0, 1'b1, 16'h0021, 16'h0000, 1'b0, 2'b10, 15'h0010, 16'h0000, 16'h0012};
    vt[6] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 1'b1, 2'b00, 15'h0000, 16'h0000, 16'h0012};
    vt[7] = '{1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, 2'b01, 15'h0010, 16'h0000, 16'h0034};

    // reset state
    #1;
    chk("rst_rdy", 32'(req_rdy_o), 32'd1);
    chk("rst_bus", {26'd0, cyc_o, stb_o, we_o, sel_o, done_o}, 32'd0);
    chk("rst_adr_dat", {1'b0, adr_o, dat_o}, 32'd0);
    chk("rst_rdat_err", {15'd0, err_o, rdat_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // test-plan vectors
    for (int i = 0; i < 8; i++) begin
      do_req(vt[i].we, vt[i].bt, vt[i].adr, vt[i].dat, d, e, lat, sc, ss, sa, sd, ssw);
      if (vt[i].exp_err) begin
        chk("vec_err", 32'(e), 32'd1);
        chk("vec_err_lat", 32'(lat), 32'd0);
        chk("vec_err_nostb", 32'(sc), 32'd0);
        chk("vec_err_rdy", 32'(req_rdy_o), 32'd1);
      end else begin
        chk("vec_done", {30'd0, d, e}, 32'd2);
        chk("vec_lat", 32'(lat), 32'd1);
        chk("vec_sel", 32'(ss), 32'(vt[i].exp_sel));
        chk("vec_adr", 32'(sa), 32'(vt[i].exp_adr));
        chk("vec_we", 32'(ssw), 32'(vt[i].we));
        if (vt[i].we) chk("vec_dat", 32'(sd), 32'(vt[i].exp_dat));
      end
      chk("vec_rdat", 32'(rdat_o), 32'(vt[i].exp_rdat));
      exp_rdat = vt[i].exp_rdat;
    end

    // timeout with a silent slave, then normal recovery
    mode = M_NONE;
    do_req(1'b0, 1'b0, 16'h0040, 16'h0, d, e, lat, sc, ss, sa, sd, ssw);
    chk("to_err", {30'd0, d, e}, 32'd1);
    chk("to_lat", 32'(lat), 32'(TIMEOUT));
    chk("to_stb_cycles", 32'(sc), 32'(TIMEOUT));
    chk("to_rdat", 32'(rdat_o), 32'(exp_rdat));
    mode = M_NEG;
    do_req(1'b0, 1'b0, 16'h0010, 16'h0, d, e, lat, sc, ss, sa, sd, ssw);
    chk("to_recover_done", 32'(d), 32'd1);
    chk("to_recover_rdat", 32'(rdat_o), 32'hBEEF);
    exp_rdat = 16'hBEEF;

    // registered slave: ack seen two edges after acceptance
    mode = M_REG;
    do_req(1'b0, 1'b1, 16'h0020, 16'h0, d, e, lat, sc, ss, sa, sd, ssw);
    chk("reg_lat", 32'(lat), 32'd2);
    chk("reg_rdat", 32'(rdat_o), 32'h0034);
    exp_rdat = 16'h0034;

    // slave holding ack an extra cycle, back-to-back transfers
    mode = M_HOLD;
    do_req(1'b1, 1'b0, 16'h0030, 16'h5A3C, d, e, lat, sc, ss, sa, sd, ssw);
    chk("hold_w_lat", {29'd0, d, e, 1'b0} | 32'(lat), 32'd5);
    do_req(1'b0, 1'b0, 16'h0030, 16'h0, d, e, lat, sc, ss, sa, sd, ssw);
    chk("hold_r_lat", 32'(lat), 32'd1);
    chk("hold_r_done", 32'(d), 32'd1);
    chk("hold_r_rdat", 32'(rdat_o), 32'h5A3C);
    exp_rdat = 16'h5A3C;

    // reset while in BUS
    mode = M_NONE;
    req_i = 1'b1; req_we_i = 1'b0; req_byte_i = 1'b0; req_adr_i = 16'h0010;
    @(posedge clk); #1;
    req_i = 1'b0;
    chk("mid_stb_up", 32'(stb_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bus", {28'd0, cyc_o, stb_o, done_o, err_o}, 32'd0);
    chk("mid_rst_rdy", 32'(req_rdy_o), 32'd1);
    chk("mid_rst_rdat", 32'(rdat_o), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold", {29'd0, stb_o, done_o, err_o}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    mode = M_NEG;
    exp_rdat = 16'h0;
    @(posedge clk); #1;
    do_req(1'b0, 1'b0, 16'h0010, 16'h0, d, e, lat, sc, ss, sa, sd, ssw);
    chk("post_rst_done", 32'(d), 32'd1);
    chk("post_rst_rdat", 32'(rdat_o), 32'hBEEF);
    exp_rdat = 16'hBEEF;

    // random pass: preload, then mixed traffic against the byte-array model
    for (int k = 0; k < 64; k += 2)
      rand_op(1'b1, 1'b0, 6'(k), 16'($urandom));
    for (int n = 0; n < 80; n++) begin
      mode = ($urandom_range(0, 1) == 0) ? M_NEG : M_REG;
      rand_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              6'($urandom_range(0, 63)), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
